edge_map_packer: RTL and testbench

//   Final stage of the Canny pipeline, directly downstream of the double-threshold stage.

---
 rtl/edge_map_packer.sv | 177 +++++++++++++++++
 tb/tb_edge_map_packer.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_map_packer.sv
// ---------------------------------------------------------------------------
// edge_map_packer
//   Last stage of the Canny pipeline. Each thresholded pixel becomes a 1-bit
//   edge flag (any non-zero bit). Flags are packed 16 per word, leftmost pixel
//   in bit 0. A new line always starts a new word. Each word is tagged with
//   SOF/EOL/EOF and buffered in a first-word-fall-through FIFO. The FIFO
//   drives a valid/ready master port.
//
// Ports
//   clk, rst_n   single rising-edge clock, asynchronous active-low reset
//   in_valid     pixel strobe (no upstream backpressure)
//   in_data      16-bit thresholded pixel
//   m_valid      FIFO head word valid
//   m_ready      sink accepts the head word
//   m_data       packed flags, bit0 = leftmost pixel
//   m_sof        head word is the first word of the frame
//   m_eol        head word is the last word of a line
//   m_eof        head word is the last word of the frame
//   overflow     sticky, a committed word was dropped because the FIFO was full
//   frame_done   one-cycle pulse after the last word of a frame is committed
// ---------------------------------------------------------------------------
module edge_map_packer #(
  parameter int IMG_W      = 632,
  parameter int IMG_H      = 504,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_data,
  output logic        m_sof,
  output logic        m_eol,
  output logic        m_eof,
  output logic        overflow,
  output logic        frame_done
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [15:0] data;
    logic        sof;
    logic        eol;
    logic        eof;
  } word_t;

  state_e          state_q;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [3:0]      idx_q, idx_d;
  logic [15:0]     shift_q, shift_d;
  logic            sof_q, sof_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            overflow_q;
  logic            frame_done_q;
  word_t           mem_q [FIFO_DEPTH];
  word_t           word_d;
  word_t           head;

  logic last_x, last_y, frame_end, commit;
  logic fifo_empty, fifo_full, pop, push;

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    last_x    = (x_q == XW'(IMG_W - 1));
    last_y    = (y_q == YW'(IMG_H - 1));
    frame_end = in_valid && last_x && last_y;
    commit    = in_valid && ((idx_q == 4'd15) || last_x);

    // Word as it would be committed this cycle, including the current pixel.
    word_d.data = shift_q | (16'(in_data != 16'd0) << idx_q);
    // SOF is decided by the position of the word's first pixel.
    word_d.sof  = (idx_q == 4'd0) ? ((x_q == '0) && (y_q == '0)) : sof_q;
    word_d.eol  = last_x;
    word_d.eof  = last_x && last_y;

    // Pointers carry one extra bit so that full and empty can be told apart.
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = ((wr_ptr_q - rd_ptr_q) == PW'(FIFO_DEPTH));
    pop        = !fifo_empty && m_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    push       = commit && (!fifo_full || pop);

    x_d     = x_q;
    y_d     = y_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    sof_d   = sof_q;
    if (in_valid) begin
      x_d     = last_x ? '0 : x_q + 1'b1;
      if (last_x) begin
        y_d = last_y ? '0 : y_q + 1'b1;
      end
      idx_d   = commit ? 4'd0 : idx_q + 4'd1;
      shift_d = commit ? 16'd0 : word_d.data;
      sof_d   = word_d.sof;
    end

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      idx_q        <= 4'd0;
      shift_q      <= 16'd0;
      sof_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      sof_q      <= sof_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_q | (commit && fifo_full && !pop);

      // A pixel arriving in DONE is pixel 0 of the next frame.
      case (state_q)
        S_IDLE, S_DONE: begin
          if (in_valid) state_q <= frame_end ? S_DONE : S_RUN;
          else          state_q <= S_IDLE;
        end
        S_RUN: begin
          if (frame_end) state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
      // This flag is high exactly while the FSM is in DONE.
      frame_done_q <= frame_end;
    end
  end

  // NOTE: the storage array has no reset. Reset empties the FIFO through the
  // pointers, and the head output is forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= word_d;
    end
  end

  always_comb begin
    head = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  assign m_valid    = !fifo_empty;
  assign m_data     = head.data;
  assign m_sof      = head.sof;
  assign m_eol      = head.eol;
  assign m_eof      = head.eof;
  assign overflow   = overflow_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_edge_map_packer.sv
module tb_edge_map_packer;

  localparam int IMG_W      = 632;
  localparam int IMG_H      = 4;     // short frame keeps full-frame runs small
  localparam int FIFO_DEPTH = 8;
  localparam int FRAME_PIX  = IMG_W * IMG_H;

  typedef struct packed {
    logic [15:0] data;
    logic        sof;
    logic        eol;
    logic        eof;
  } word_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_sof, m_eol, m_eof;
  logic        overflow;
  logic        frame_done;

  edge_map_packer #(
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_sof      (m_sof),
    .m_eol      (m_eol),
    .m_eof      (m_eof),
    .overflow   (overflow),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: linear pixel index within the frame plus a word being built.
  word_t       mq[$];     // words the FIFO should hold, head first
  word_t       got[$];    // words observed leaving the DUT
  bit          ovf_m;
  bit          fd_m;
  int          fd_seen;
  int          mdl_n;
  int          mdl_cnt;
  int          mdl_start;
  logic [15:0] mdl_bits;

  task automatic model_clear();
    mq.delete();
    got.delete();
    ovf_m     = 1'b0;
    fd_m      = 1'b0;
    fd_seen   = 0;
    mdl_n     = 0;
    mdl_cnt   = 0;
    mdl_start = 0;
    mdl_bits  = 16'd0;
  endtask

  // Drive one cycle, compare the outputs with the model, then advance the model.
  task automatic step(input bit v, input logic [15:0] d, input bit r);
    word_t w;
    word_t obs;
    bit    pop_m;
    int    occ;
    int    x, y;
    in_valid = v;
    in_data  = d;
    m_ready  = r;
    #1;
    obs = '{data: m_data, sof: m_sof, eol: m_eol, eof: m_eof};
    n_cmp++;
    if (m_valid !== (mq.size() > 0)) begin
      n_bad++;
      $display("FAIL stream_valid: got %b want %b", m_valid, mq.size() > 0);
    end
    if (mq.size() > 0) begin
      n_cmp++;
      if (obs !== mq[0]) begin
        n_bad++;
        $display("FAIL stream_word: got %h sof%b eol%b eof%b want %h sof%b eol%b eof%b",
                 obs.data, obs.sof, obs.eol, obs.eof,
                 mq[0].data, mq[0].sof, mq[0].eol, mq[0].eof);
      end
    end
    n_cmp++;
    if (overflow !== ovf_m) begin
      n_bad++;
      $display("FAIL overflow: got %b want %b", overflow, ovf_m);
    end
    n_cmp++;
    if (frame_done !== fd_m) begin
      n_bad++;
      $display("FAIL frame_done: got %b want %b", frame_done, fd_m);
    end
    if (frame_done === 1'b1) fd_seen++;

    occ   = mq.size();
    pop_m = (occ > 0) && r;
    if (pop_m) begin
      got.push_back(obs);
      void'(mq.pop_front());
    end
    fd_m = 1'b0;
    if (v) begin
      x = mdl_n % IMG_W;
      y = mdl_n / IMG_W;
      if (mdl_cnt == 0) mdl_start = mdl_n;
      if (d != 16'd0) mdl_bits[mdl_cnt] = 1'b1;
      mdl_cnt++;
      if (mdl_cnt == 16 || x == IMG_W - 1) begin
        w.data = mdl_bits;
        w.sof  = (mdl_start == 0);
        w.eol  = (x == IMG_W - 1);
        w.eof  = w.eol && (y == IMG_H - 1);
        if (occ < FIFO_DEPTH || pop_m) mq.push_back(w);
        else                           ovf_m = 1'b1;
        mdl_cnt  = 0;
        mdl_bits = 16'd0;
      end
      if (mdl_n == FRAME_PIX - 1) fd_m = 1'b1;
      mdl_n = (mdl_n + 1) % FRAME_PIX;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    m_ready  = 1'b0;
    #2 rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 16'd0;
    m_ready  = 1'b0;
    model_clear();
    #1;
    n_cmp++;
    if ({m_valid, m_data, m_sof, m_eol, m_eof, overflow, frame_done} !== 22'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v%b d%h %b%b%b o%b f%b want all 0",
               m_valid, m_data, m_sof, m_eol, m_eof, overflow, frame_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 16'd0, 1'b1);
  endtask

  task automatic test_line_ones();
    do_reset();
    for (int i = 0; i < IMG_W; i++) step(1'b1, 16'h0001, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 16'd0, 1'b1);
    n_cmp++;
    if (got.size() != 40) begin
      n_bad++;
      $display("FAIL line_word_count: got %0d want 40", got.size());
    end else begin
      n_cmp++;
      if (got[0].data !== 16'hFFFF || got[0].sof !== 1'b1 || got[0].eol !== 1'b0) begin
        n_bad++;
        $display("FAIL line_first_word: got %h sof%b eol%b want ffff sof1 eol0",
                 got[0].data, got[0].sof, got[0].eol);
      end
      n_cmp++;
      if (got[38].data !== 16'hFFFF || got[38].sof !== 1'b0) begin
        n_bad++;
        $display("FAIL line_word38: got %h sof%b want ffff sof0", got[38].data, got[38].sof);
      end
      n_cmp++;
      if (got[39].data !== 16'h00FF || got[39].eol !== 1'b1 || got[39].eof !== 1'b0) begin
        n_bad++;
        $display("FAIL line_last_word: got %h eol%b eof%b want 00ff eol1 eof0",
                 got[39].data, got[39].eol, got[39].eof);
      end
    end
  endtask

  task automatic test_alternating();
    int n_ok;
    do_reset();
    for (int i = 0; i < IMG_W; i++) step(1'b1, (i % 2 == 1) ? 16'h8000 : 16'h0000, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 16'd0, 1'b1);
    n_ok = 0;
    for (int i = 0; i < got.size(); i++) begin
      if (got[i].data === ((i == 39) ? 16'h00AA : 16'hAAAA)) n_ok++;
    end
    n_cmp++;
    if (got.size() != 40 || n_ok != 40) begin
      n_bad++;
      $display("FAIL alt_words: got %0d words %0d correct want 40 words 40 correct",
               got.size(), n_ok);
    end
  endtask

  task automatic test_full_frame();
    do_reset();
    for (int i = 0; i < FRAME_PIX; i++) step(1'b1, 16'h0001, 1'b1);
    // First 16 pixels of the next frame, the first one arriving while in DONE.
    for (int i = 0; i < 16; i++) step(1'b1, 16'h0001, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 16'd0, 1'b1);
    n_cmp++;
    if (got.size() != 40 * IMG_H + 1) begin
      n_bad++;
      $display("FAIL frame_word_count: got %0d want %0d", got.size(), 40 * IMG_H + 1);
    end else begin
      n_cmp++;
      if (got[40*IMG_H-1].data !== 16'h00FF || got[40*IMG_H-1].eof !== 1'b1) begin
        n_bad++;
        $display("FAIL frame_last_word: got %h eof%b want 00ff eof1",
                 got[40*IMG_H-1].data, got[40*IMG_H-1].eof);
      end
      n_cmp++;
      if (got[40*IMG_H].sof !== 1'b1 || got[40*IMG_H].data !== 16'hFFFF) begin
        n_bad++;
        $display("FAIL next_frame_sof: got %h sof%b want ffff sof1",
                 got[40*IMG_H].data, got[40*IMG_H].sof);
      end
    end
    n_cmp++;
    if (fd_seen != 1) begin
      n_bad++;
      $display("FAIL frame_done_pulses: got %0d want 1", fd_seen);
    end
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL frame_overflow: got %b want 0", overflow);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    // Word k carries flags in bits 0..k, so every word is distinguishable.
    for (int i = 0; i < 9 * 16; i++) step(1'b1, ((i % 16) <= (i / 16)) ? 16'h0101 : 16'h0000, 1'b0);
    step(1'b0, 16'd0, 1'b0);
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_set: got %b want 1", overflow);
    end
    for (int i = 0; i < 12; i++) step(1'b0, 16'd0, 1'b1);
    n_cmp++;
    if (got.size() != 8) begin
      n_bad++;
      $display("FAIL ovf_drain_count: got %0d want 8", got.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        logic [15:0] want;
        want = 16'((32'd1 << (k + 1)) - 32'd1);
        n_cmp++;
        if (got[k].data !== want) begin
          n_bad++;
          $display("FAIL ovf_order[%0d]: got %h want %h", k, got[k].data, want);
        end
      end
    end
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_sticky: got %b want 1", overflow);
    end
    do_reset();
    #1;
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_cleared: got %b want 0", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 8 * 16 + 15; i++) step(1'b1, 16'h0001, 1'b0);
    step(1'b1, 16'h0001, 1'b1);   // commit while full, with a pop in the same cycle
    n_cmp++;
    if (overflow !== 1'b0 || mq.size() != 8) begin
      n_bad++;
      $display("FAIL push_pop_full: got ovf %b model depth %0d want ovf 0 depth 8",
               overflow, mq.size());
    end
    for (int i = 0; i < 12; i++) step(1'b0, 16'd0, 1'b1);
    n_cmp++;
    if (got.size() != 9) begin
      n_bad++;
      $display("FAIL push_pop_count: got %0d want 9", got.size());
    end
  endtask

  task automatic test_reset_mid_line();
    do_reset();
    for (int i = 0; i < 100; i++) step(1'b1, 16'h0001, 1'b0);
    #1;
    n_cmp++;
    if (m_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_valid: got %b want 1", m_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({m_valid, m_data, m_sof, m_eol, m_eof, overflow, frame_done} !== 22'd0) begin
      n_bad++;
      $display("FAIL async_reset_outputs: got v%b d%h %b%b%b o%b f%b want all 0",
               m_valid, m_data, m_sof, m_eol, m_eof, overflow, frame_done);
    end
    model_clear();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) step(1'b1, 16'h0001, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, 16'd0, 1'b1);
    n_cmp++;
    if (got.size() != 1 || got[0].sof !== 1'b1 || got[0].data !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL post_reset_sof: got %0d words sof%b want 1 word ffff sof1",
               got.size(), (got.size() > 0) ? got[0].sof : 1'bx);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3600; i++) begin
      step($urandom_range(0, 3) != 0,
           ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'd0,
           $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 20; i++) step(1'b0, 16'd0, 1'b1);
    #1;
    n_cmp++;
    if (m_valid !== 1'b0 || mq.size() != 0) begin
      n_bad++;
      $display("FAIL random_drained: got valid %b model depth %0d want 0 0", m_valid, mq.size());
    end
  endtask

  initial begin
    test_reset();
    test_line_ones();
    test_alternating();
    test_full_frame();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_line();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
